// File: rtl/jpeg_scan_bit_unpacker.sv
// rtl/jpeg_scan_bit_unpacker.sv - JPEG scan byte unstuffer and MSB-first bit window for the Huffman decoder
module jpeg_scan_bit_unpacker #(
  parameter int BUF_W  = 32,
  parameter int PEEK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_scan,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [PEEK_W-1:0] peek_bits,
  output logic [5:0]        bits_avail,
  input  logic              consume_valid,
  input  logic [4:0]        consume_len,
  output logic              marker_valid,
  output logic [7:0]        marker_code,
  input  logic              marker_ack,
  output logic              scan_done,
  output logic              marker_err,
  output logic              underflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_FF   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [BUF_W-1:0] buffer;   // left-aligned, bits below avail are always zero
  logic [5:0]       avail;

  logic             byte_acc;
  logic             consume_ok;
  logic             append;
  logic [7:0]       app_byte;
  logic [5:0]       rem;
  logic [5:0]       avail_next;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] placed;
  logic [BUF_W-1:0] buf_next;
  logic             is_marker;

  assign byte_ready = ((state == S_DATA) || (state == S_FF)) && !marker_valid
                      && (avail <= 6'(BUF_W - 8));
  assign peek_bits  = buffer[BUF_W-1 -: PEEK_W];
  assign bits_avail = avail;
  assign is_marker  = ((byte_in >= 8'hD0) && (byte_in <= 8'hD7)) || (byte_in == 8'hD9);

  // Next buffer image: drop consumed bits from the top, then drop the new byte just below what remains
  always_comb begin
    byte_acc   = byte_valid && byte_ready;
    consume_ok = consume_valid && ({1'b0, consume_len} <= avail);
    rem        = avail;
    shifted    = buffer;
    if (consume_ok) begin
      rem     = avail - {1'b0, consume_len};
      shifted = buffer << consume_len;
    end
    append   = byte_acc && (((state == S_DATA) && (byte_in != 8'hFF)) ||
                            ((state == S_FF) && (byte_in == 8'h00)));
    app_byte = (state == S_FF) ? 8'hFF : byte_in;
    placed   = {app_byte, {(BUF_W-8){1'b0}}} >> rem;
    buf_next   = append ? (shifted | placed) : shifted;
    avail_next = append ? (rem + 6'd8) : rem;
  end

  // Scan state, bit buffer and marker handling; start_scan overrides everything, then marker_ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      buffer       <= '0;
      avail        <= '0;
      marker_valid <= 1'b0;
      marker_code  <= 8'h00;
      scan_done    <= 1'b0;
      marker_err   <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      marker_err <= 1'b0;
      underflow  <= 1'b0;
      if (start_scan) begin
        buffer       <= '0;
        avail        <= '0;
        marker_valid <= 1'b0;
        scan_done    <= 1'b0;
        state        <= S_DATA;
      end else if (marker_ack && marker_valid) begin
        // Any bits left before the marker are padding and are thrown away
        buffer       <= '0;
        avail        <= '0;
        marker_valid <= 1'b0;
        if (marker_code == 8'hD9) begin
          scan_done <= 1'b1;
          state     <= S_DONE;
        end
      end else begin
        buffer <= buf_next;
        avail  <= avail_next;
        if (consume_valid && !consume_ok) begin
          underflow <= 1'b1;
        end
        if (byte_acc) begin
          case (state)
            S_DATA: begin
              if (byte_in == 8'hFF) begin
                state <= S_FF;
              end
            end
            S_FF: begin
              if (byte_in == 8'h00) begin
                state <= S_DATA;
              end else if (byte_in == 8'hFF) begin
                state <= S_FF;
              end else if (is_marker) begin
                marker_valid <= 1'b1;
                marker_code  <= byte_in;
                state        <= S_DATA;
              end else begin
                marker_err <= 1'b1;
                state      <= S_DATA;
              end
            end
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_scan_bit_unpacker.sv
// tb/tb_jpeg_scan_bit_unpacker.sv - self-checking bench for jpeg_scan_bit_unpacker
module tb_jpeg_scan_bit_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_scan;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] peek_bits;
  logic [5:0]  bits_avail;
  logic        consume_valid;
  logic [4:0]  consume_len;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        scan_done;
  logic        marker_err;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  jpeg_scan_bit_unpacker #(.BUF_W(32), .PEEK_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_scan(start_scan), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .peek_bits(peek_bits),
    .bits_avail(bits_avail), .consume_valid(consume_valid), .consume_len(consume_len),
    .marker_valid(marker_valid), .marker_code(marker_code), .marker_ack(marker_ack),
    .scan_done(scan_done), .marker_err(marker_err), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        bv;
    logic [7:0]  b;
    logic        cv;
    logic [4:0]  cl;
    logic        ack;
    int          avail;
    logic [15:0] peek;
    logic        rdy;
    logic        mv;
    logic        err;
    logic        uf;
  } vec_t;

  vec_t vt[$];

  // Behavioural model: the scan as a queue of bits, oldest first
  bit         mq[$];
  int         m_st;   // 0 idle, 1 data, 2 after FF, 3 done
  logic       m_mv, m_done, m_err, m_uf;
  logic [7:0] m_code;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(logic start, logic bv, logic [7:0] b, logic cv, logic [4:0] cl, logic ack,
                     int avail, logic [15:0] peek, logic rdy, logic mv, logic err, logic uf);
    vec_t v;
    v.start = start; v.bv = bv; v.b = b; v.cv = cv; v.cl = cl; v.ack = ack;
    v.avail = avail; v.peek = peek; v.rdy = rdy; v.mv = mv; v.err = err; v.uf = uf;
    vt.push_back(v);
  endtask

  task automatic cyc(logic start, logic bv, logic [7:0] b, logic cv, logic [4:0] cl, logic ack);
    start_scan = start; byte_valid = bv; byte_in = b;
    consume_valid = cv; consume_len = cl; marker_ack = ack;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_peek();
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < mq.size()) p[15-i] = mq[i];
    end
    return p;
  endfunction

  task automatic m_push(logic [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endtask

  task automatic model_step();
    logic rdy;
    rdy   = ((m_st == 1) || (m_st == 2)) && !m_mv && (mq.size() <= 24);
    m_err = 1'b0;
    m_uf  = 1'b0;
    if (start_scan) begin
      mq.delete(); m_mv = 1'b0; m_done = 1'b0; m_st = 1;
    end else if (marker_ack && m_mv) begin
      mq.delete(); m_mv = 1'b0;
      if (m_code == 8'hD9) begin m_done = 1'b1; m_st = 3; end
    end else begin
      if (consume_valid) begin
        if (consume_len <= mq.size()) repeat (consume_len) void'(mq.pop_front());
        else m_uf = 1'b1;
      end
      if (byte_valid && rdy) begin
        if (m_st == 1) begin
          if (byte_in == 8'hFF) m_st = 2;
          else m_push(byte_in);
        end else begin
          if (byte_in == 8'h00) begin m_push(8'hFF); m_st = 1; end
          else if (byte_in == 8'hFF) m_st = 2;
          else if ((byte_in >= 8'hD0 && byte_in <= 8'hD7) || byte_in == 8'hD9) begin
            m_mv = 1'b1; m_code = byte_in; m_st = 1;
          end else begin
            m_err = 1'b1; m_st = 1;
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_scan = 0; byte_in = 0; byte_valid = 0; consume_valid = 0; consume_len = 0; marker_ack = 0;
    #12;
    chk("rst_avail", bits_avail, 0);
    chk("rst_peek", peek_bits, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_mv", marker_valid, 0);
    chk("rst_code", marker_code, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_err", marker_err, 0);
    chk("rst_uf", underflow, 0);
    rst_n = 1'b1;

    //  st bv byte  cv len ack | avail peek     rdy mv err uf
    add(1, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 8'h12, 0, 0, 0,   8, 16'h1200, 1, 0, 0, 0);
    add(0, 1, 8'h34, 0, 0, 0,  16, 16'h1234, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 4, 0,  12, 16'h2340, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 12, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 8'hAB, 0, 0, 0,   8, 16'hAB00, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0,   8, 16'hAB00, 1, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0,  16, 16'hABFF, 1, 0, 0, 0);
    add(0, 1, 8'hCD, 0, 0, 0,  24, 16'hABFF, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 24, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 8'h55, 0, 0, 0,   8, 16'h5500, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0,   8, 16'h5500, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0,   8, 16'h5500, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0,   8, 16'h5500, 1, 0, 0, 0);
    add(0, 1, 8'hD3, 0, 0, 0,   8, 16'h5500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 8, 0,   0, 16'h0000, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1,   0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 8'h01, 0, 0, 0,   8, 16'h0100, 1, 0, 0, 0);
    add(0, 1, 8'h02, 0, 0, 0,  16, 16'h0102, 1, 0, 0, 0);
    add(0, 1, 8'h03, 0, 0, 0,  24, 16'h0102, 1, 0, 0, 0);
    add(0, 1, 8'h04, 0, 0, 0,  32, 16'h0102, 0, 0, 0, 0);
    add(0, 1, 8'h05, 1, 8, 0,  24, 16'h0203, 1, 0, 0, 0);
    add(0, 1, 8'h05, 1, 8, 0,  24, 16'h0304, 1, 0, 0, 0);
    add(0, 1, 8'h06, 1, 4, 0,  28, 16'h3040, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 20, 0,  8, 16'h0600, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 9, 0,   8, 16'h0600, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 8, 0,   0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 8'hC4, 0, 0, 0,   0, 16'h0000, 1, 0, 1, 0);
    add(0, 1, 8'h77, 0, 0, 0,   8, 16'h7700, 1, 0, 0, 0);

    foreach (vt[i]) begin
      cyc(vt[i].start, vt[i].bv, vt[i].b, vt[i].cv, vt[i].cl, vt[i].ack);
      chk($sformatf("v%0d_avail", i), bits_avail, vt[i].avail);
      chk($sformatf("v%0d_peek", i), peek_bits, vt[i].peek);
      chk($sformatf("v%0d_ready", i), byte_ready, vt[i].rdy);
      chk($sformatf("v%0d_mv", i), marker_valid, vt[i].mv);
      chk($sformatf("v%0d_err", i), marker_err, vt[i].err);
      chk($sformatf("v%0d_uf", i), underflow, vt[i].uf);
    end

    // Stray ack, then EOI handling and re-arm
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("stray_ack_avail", bits_avail, 8);
    cyc(0, 1, 8'hFF, 1, 8, 0);
    chk("eoi_pre_avail", bits_avail, 0);
    cyc(0, 1, 8'hD9, 0, 0, 0);
    chk("eoi_mv", marker_valid, 1);
    chk("eoi_code", marker_code, 8'hD9);
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("eoi_done", scan_done, 1);
    chk("eoi_ready", byte_ready, 0);
    chk("eoi_mv_clr", marker_valid, 0);
    cyc(0, 1, 8'h11, 0, 0, 0);
    chk("done_blocked", bits_avail, 0);
    cyc(0, 0, 8'h00, 1, 1, 0);
    chk("done_uf", underflow, 1);
    cyc(0, 0, 8'h00, 1, 0, 0);
    chk("done_len0_uf", underflow, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    chk("restart_done", scan_done, 0);
    chk("restart_ready", byte_ready, 1);
    cyc(0, 1, 8'h9A, 0, 0, 0);
    cyc(0, 1, 8'hBC, 0, 0, 0);
    chk("restart_peek", peek_bits, 16'h9ABC);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_avail", bits_avail, 0);
    chk("arst_peek", peek_bits, 0);
    chk("arst_done", scan_done, 0);
    chk("arst_code", marker_code, 0);
    chk("arst_ready", byte_ready, 0);
    rst_n = 1'b1;
    cyc(0, 1, 8'h42, 0, 0, 0);
    chk("idle_ignores_byte", bits_avail, 0);

    // Randomized traffic against the model
    mq.delete(); m_st = 0; m_mv = 0; m_done = 0; m_err = 0; m_uf = 0; m_code = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      logic        s, bv, cv, ak;
      logic [7:0]  b;
      logic [4:0]  cl;
      int          r;
      s  = (n == 0) || m_done || ($urandom_range(0, 199) == 0);
      bv = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 39);
      if (r < 6)       b = 8'hFF;
      else if (r < 8)  b = 8'h00;
      else if (r < 9)  b = 8'hD0 + 8'($urandom_range(0, 7));
      else if (r < 10) b = 8'hC4;
      else if (r < 11 && $urandom_range(0, 3) == 0) b = 8'hD9;
      else             b = 8'($urandom_range(0, 255));
      cv = ($urandom_range(0, 1) != 0);
      cl = 5'($urandom_range(0, 17));
      ak = m_mv && ($urandom_range(0, 2) == 0);
      start_scan = s; byte_valid = bv; byte_in = b;
      consume_valid = cv; consume_len = cl; marker_ack = ak;
      model_step();
      @(posedge clk);
      #1;
      chk("rnd_avail", bits_avail, mq.size());
      chk("rnd_peek", peek_bits, m_peek());
      chk("rnd_ready", byte_ready, ((m_st == 1) || (m_st == 2)) && !m_mv && (mq.size() <= 24));
      chk("rnd_mv", marker_valid, m_mv);
      chk("rnd_code", marker_code, m_code);
      chk("rnd_done", scan_done, m_done);
      chk("rnd_err", marker_err, m_err);
      chk("rnd_uf", underflow, m_uf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
